// File: rtl/m_multicycle_core.sv
// Multi-cycle RV32I-subset core (ADDI/ADD/SUB/LUI/LW/SW) with private IMEM, DMEM and register file.
// Define M_CORE_BRANCH_EN to build BEQ/BNE; without it opcode 11000 executes as a NOP.
module m_multicycle_core #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [4:0]  HALT_REG   = 5'd30
) (
    input  logic        w_clock,
    input  logic        w_rst,
    input  logic        w_imem_we,
    input  logic [31:0] w_imem_waddr,
    input  logic [31:0] w_imem_wdata,
    output logic [31:0] w_pc,
    output logic [2:0]  w_state,
    output logic        w_retire,
    output logic        w_wb_en,
    output logic [4:0]  w_wb_addr,
    output logic [31:0] w_wb_data,
    output logic        w_halt
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;
    typedef enum logic [2:0] {K_NOP, K_ADDI, K_ADD, K_SUB, K_LUI, K_LW, K_SW, K_BR} kind_t;

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_addr, r_wb_data;
    logic [4:0]  r_wb_addr;
    logic        r_retire, r_wb_en, r_halt;
    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_rf   [32];

    logic [4:0]     w_rd, w_rs1, w_rs2;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;
    kind_t          w_kind;
    logic [31:0]    w_imm, w_result;
    logic [IAW-1:0] w_ifetch_idx, w_iwrite_idx;
    logic [DAW-1:0] w_dmem_idx;
    logic           w_unused;

    assign w_rd         = r_ir[11:7];
    assign w_rs1        = r_ir[19:15];
    assign w_rs2        = r_ir[24:20];
    assign w_funct3     = r_ir[14:12];
    assign w_funct7     = r_ir[31:25];
    assign w_ifetch_idx = r_pc[IAW+1:2];
    assign w_iwrite_idx = w_imem_waddr[IAW+1:2];
    assign w_dmem_idx   = r_addr[DAW+1:2];
    assign w_unused     = ^{w_imem_waddr[31:IAW+2], w_imem_waddr[1:0], r_addr[31:DAW+2], r_addr[1:0]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_kind = K_NOP;
        if (r_ir[1:0] == 2'b11) begin
            case (r_ir[6:2])
                5'b00100: if (w_funct3 == 3'b000) w_kind = K_ADDI;
                5'b01100: begin
                    if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000)      w_kind = K_ADD;
                    else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) w_kind = K_SUB;
                end
                5'b01101: w_kind = K_LUI;
                5'b00000: if (w_funct3 == 3'b010) w_kind = K_LW;
                5'b01000: if (w_funct3 == 3'b010) w_kind = K_SW;
`ifdef M_CORE_BRANCH_EN
                5'b11000: if (w_funct3[2:1] == 2'b00) w_kind = K_BR;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_kind)
            K_LUI:   w_imm = {r_ir[31:12], 12'h000};
            K_SW:    w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            K_BR:    w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            default: ;
        endcase
    end

    always_comb begin
        w_result = r_a + r_imm;
        case (w_kind)
            K_ADD:   w_result = r_a + r_b;
            K_SUB:   w_result = r_a - r_b;
            K_LUI:   w_result = r_imm;
            default: ;
        endcase
    end

`ifdef M_CORE_BRANCH_EN
    logic w_take;
    assign w_take = w_funct3[0] ? (r_a != r_b) : (r_a == r_b);
`endif

    // NOTE: non-blocking IMEM write means an IF on the same edge and index still sees the old word.
    always_ff @(posedge w_clock) begin
        if (w_imem_we) r_imem[w_iwrite_idx] <= w_imem_wdata;
    end

    always_ff @(posedge w_clock) begin
        if (w_rst) begin
            r_state   <= S_IF;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_addr    <= '0;
            r_retire  <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_halt    <= 1'b0;
            // NOTE: RF and DMEM are architecturally cleared by reset, so they are reset flop arrays, unlike IMEM.
            for (int i = 0; i < 32; i++)         r_rf[i[4:0]]       <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i[DAW-1:0]] <= '0;
        end else begin
            r_retire <= 1'b0;
            r_wb_en  <= 1'b0;
            case (r_state)
                S_IF: begin
                    r_ir    <= r_imem[w_ifetch_idx];
                    r_state <= S_ID;
                end
                S_ID: begin
                    r_a      <= (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
                    r_b      <= (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
                    r_imm    <= w_imm;
                    r_retire <= (w_kind == K_NOP) || (w_kind == K_BR);
                    r_state  <= S_EX;
                end
                S_EX: begin
                    case (w_kind)
                        K_ADDI, K_ADD, K_SUB, K_LUI: begin
                            r_wb_data <= w_result;
                            r_wb_addr <= w_rd;
                            r_wb_en   <= (w_rd != 5'd0);
                            r_retire  <= 1'b1;
                            r_state   <= S_WB;
                        end
                        K_LW, K_SW: begin
                            r_addr   <= w_result;
                            r_retire <= (w_kind == K_SW);
                            r_state  <= S_MEM;
                        end
                        K_BR: begin
`ifdef M_CORE_BRANCH_EN
                            r_pc <= w_take ? r_pc + r_imm : r_pc + 32'd4;
`else
                            r_pc <= r_pc + 32'd4;
`endif
                            r_state <= S_IF;
                        end
                        default: begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= S_IF;
                        end
                    endcase
                end
                S_MEM: begin
                    if (w_kind == K_LW) begin
                        r_wb_data <= r_dmem[w_dmem_idx];
                        r_wb_addr <= w_rd;
                        r_wb_en   <= (w_rd != 5'd0);
                        r_retire  <= 1'b1;
                        r_state   <= S_WB;
                    end else begin
                        r_dmem[w_dmem_idx] <= r_b;
                        r_pc               <= r_pc + 32'd4;
                        r_state            <= S_IF;
                    end
                end
                S_WB: begin
                    if (r_wb_en) r_rf[r_wb_addr] <= r_wb_data;
                    r_pc <= r_pc + 32'd4;
                    if (r_wb_en && r_wb_addr == HALT_REG) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_IF;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IF;
            endcase
        end
    end

    assign w_pc      = r_pc;
    assign w_state   = r_state;
    assign w_retire  = r_retire;
    assign w_wb_en   = r_wb_en;
    assign w_wb_addr = r_wb_addr;
    assign w_wb_data = r_wb_data;
    assign w_halt    = r_halt;
endmodule

// File: tb/tb_m_multicycle_core.sv
// Bench for m_multicycle_core: directed programs plus random programs checked against an
// instruction-level reference model (one call = one whole instruction's architectural effect).
module tb_m_multicycle_core;
    localparam int IW = 64;
    localparam int DW = 64;

    logic        w_clock = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_imem_we = 1'b0;
    logic [31:0] w_imem_waddr = '0;
    logic [31:0] w_imem_wdata = '0;
    logic [31:0] w_pc;
    logic [2:0]  w_state;
    logic        w_retire, w_wb_en, w_halt;
    logic [4:0]  w_wb_addr;
    logic [31:0] w_wb_data;

    m_multicycle_core dut (
        .w_clock(w_clock), .w_rst(w_rst),
        .w_imem_we(w_imem_we), .w_imem_waddr(w_imem_waddr), .w_imem_wdata(w_imem_wdata),
        .w_pc(w_pc), .w_state(w_state), .w_retire(w_retire),
        .w_wb_en(w_wb_en), .w_wb_addr(w_wb_addr), .w_wb_data(w_wb_data), .w_halt(w_halt)
    );

    always #5 w_clock = ~w_clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_imem [IW];
    logic [31:0] m_dmem [DW];
    logic [31:0] m_rf   [32];
    logic [31:0] m_pc;

    typedef struct {
        int          lat;
        int          state;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } exp_t;

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[19:0], rd, 7'h37};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < DW; i++) m_dmem[i] = '0;
    endtask

    // Architectural effect of the instruction at m_pc, plus its expected retire timing.
    task automatic model_step(output exp_t e);
        logic [31:0] ins, a, b, imm_i, imm_s, res;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        bit          has_wb, is_load;
        ins    = m_imem[int'((m_pc >> 2) % IW)];
        op     = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        rd     = ins[11:7];
        a      = m_rf[ins[19:15]];
        b      = m_rf[ins[24:20]];
        imm_i  = {{20{ins[31]}}, ins[31:20]};
        imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        has_wb = 0;
        is_load = 0;
        res    = '0;
        e.lat = 3; e.state = 2; e.wb_en = 0; e.wb_addr = '0; e.wb_data = '0;
        if (op == 7'h13 && f3 == 3'd0) begin
            has_wb = 1; res = a + imm_i;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
            has_wb = 1; res = a + b;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
            has_wb = 1; res = a - b;
        end else if (op == 7'h37) begin
            has_wb = 1; res = {ins[31:12], 12'h000};
        end else if (op == 7'h03 && f3 == 3'd2) begin
            has_wb = 1; is_load = 1; res = m_dmem[int'(((a + imm_i) >> 2) % DW)];
        end else if (op == 7'h23 && f3 == 3'd2) begin
            m_dmem[int'(((a + imm_s) >> 2) % DW)] = b;
            e.lat = 4; e.state = 3;
        end
`ifdef M_CORE_BRANCH_EN
        else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            if ((f3 == 3'd0) == (a == b))
                m_pc = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} - 32'd4;
        end
`endif
        if (has_wb) begin
            e.lat = is_load ? 5 : 4;
            e.state = 4;
            e.wb_en = (rd != 5'd0);
            e.wb_addr = rd;
            e.wb_data = res;
            if (rd != 5'd0) m_rf[rd] = res;
        end
        m_pc = m_pc + 32'd4;
    endtask

    task automatic load_program(input logic [31:0] prog[$]);
        w_rst = 1'b1;
        for (int i = 0; i < IW; i++) begin
            @(negedge w_clock);
            w_imem_we    = 1'b1;
            w_imem_waddr = 32'(i * 4);
            w_imem_wdata = (i < prog.size()) ? prog[i] : 32'h0;
            m_imem[i]    = w_imem_wdata;
        end
        @(negedge w_clock);
        w_imem_we = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge w_clock);
        #1 w_rst = 1'b0;
    endtask

    // Runs n instructions from the current point, comparing each against the model.
    task automatic run_and_compare(input int n, input string tag);
        exp_t        e;
        int          cyc;
        bit          seen;
        logic [31:0] start_pc;
        for (int k = 0; k < n; k++) begin
            start_pc = m_pc;
            model_step(e);
            cyc  = 0;
            seen = 0;
            while (!seen && cyc < 12) begin
                @(negedge w_clock);
                cyc++;
                if (cyc == 1) begin
                    n_tests++;
                    if (w_pc !== start_pc || w_state !== 3'd0) begin
                        n_fail++;
                        $display("FAIL %s[%0d] fetch: pc=%h state=%0d, want pc=%h state=0", tag, k, w_pc, w_state, start_pc);
                    end
                end
                if (w_retire === 1'b1) seen = 1;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL %s[%0d] timeout: no retire within 12 cycles, want %0d", tag, k, e.lat);
                return;
            end
            if (cyc != e.lat || w_state !== 3'(e.state) || w_pc !== start_pc) begin
                n_fail++;
                $display("FAIL %s[%0d] retire: cycles=%0d state=%0d pc=%h, want cycles=%0d state=%0d pc=%h",
                         tag, k, cyc, w_state, w_pc, e.lat, e.state, start_pc);
            end
            n_tests++;
            if (w_wb_en !== e.wb_en || (e.wb_en && (w_wb_addr !== e.wb_addr || w_wb_data !== e.wb_data))) begin
                n_fail++;
                $display("FAIL %s[%0d] writeback: en=%b x%0d=%h, want en=%b x%0d=%h",
                         tag, k, w_wb_en, w_wb_addr, w_wb_data, e.wb_en, e.wb_addr, e.wb_data);
            end
        end
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        repeat (2) @(posedge w_clock);
        @(negedge w_clock);
        n_tests++;
        if (w_pc !== 32'h0 || w_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset pc/state: pc=%h state=%0d, want 0/0", w_pc, w_state);
        end
        n_tests++;
        if ({w_retire, w_wb_en, w_halt} !== 3'b000 || w_wb_addr !== 5'd0 || w_wb_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset outputs: retire=%b wb_en=%b halt=%b addr=%0d data=%h, want all 0",
                     w_retire, w_wb_en, w_halt, w_wb_addr, w_wb_data);
        end
    endtask

    task automatic test_addi_chain();
        logic [31:0] prog[$];
        prog = {enc_addi(5'd1, 5'd0, 32'd3), enc_addi(5'd2, 5'd1, 32'd4), enc_addi(5'd3, 5'd2, 32'd5)};
        load_program(prog);
        release_reset();
        run_and_compare(3, "addi_chain");
    endtask

    task automatic test_add_sub();
        logic [31:0] prog[$];
        prog = {enc_addi(5'd1, 5'd0, 32'd3), enc_addi(5'd2, 5'd0, 32'd7),
                enc_add(5'd4, 5'd1, 5'd2), enc_sub(5'd5, 5'd1, 5'd2), enc_add(5'd0, 5'd1, 5'd2)};
        load_program(prog);
        release_reset();
        run_and_compare(5, "add_sub");
    endtask

    task automatic test_lui_mem();
        logic [31:0] prog[$];
        prog = {enc_lui(5'd6, 32'h12345), enc_sw(5'd6, 5'd0, 32'd8), enc_lw(5'd7, 5'd0, 32'd8),
                enc_addi(5'd8, 5'd0, 32'hFFC), enc_sw(5'd7, 5'd8, 32'd0), enc_lw(5'd9, 5'd0, 32'hFC)};
        load_program(prog);
        release_reset();
        run_and_compare(6, "lui_mem");
    endtask

    task automatic test_halt();
        logic [31:0] prog[$];
        bit          bad;
        prog = {enc_addi(5'd5, 5'd0, 32'd7), enc_addi(5'd30, 5'd0, 32'd1), enc_addi(5'd6, 5'd0, 32'd9)};
        load_program(prog);
        release_reset();
        run_and_compare(2, "halt");
        @(negedge w_clock);
        n_tests++;
        if (w_halt !== 1'b1 || w_state !== 3'd5 || w_pc !== 32'd8) begin
            n_fail++;
            $display("FAIL halt entry: halt=%b state=%0d pc=%h, want 1/5/00000008", w_halt, w_state, w_pc);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge w_clock);
            if (w_halt !== 1'b1 || w_state !== 3'd5 || w_pc !== 32'd8 || w_retire !== 1'b0 || w_wb_en !== 1'b0)
                bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL halt hold: state=%0d pc=%h retire=%b wb_en=%b, want frozen 5/00000008/0/0",
                     w_state, w_pc, w_retire, w_wb_en);
        end
        w_rst = 1'b1;
        @(negedge w_clock);
        n_tests++;
        if (w_pc !== 32'h0 || w_state !== 3'd0 || w_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt exit: pc=%h state=%0d halt=%b, want 0/0/0", w_pc, w_state, w_halt);
        end
    endtask

    task automatic test_branch();
        logic [31:0] prog[$];
        prog = {enc_addi(5'd1, 5'd0, 32'd3), enc_br(3'd0, 5'd1, 5'd1, 32'd8), enc_addi(5'd2, 5'd0, 32'd1),
                enc_addi(5'd3, 5'd0, 32'd2), enc_br(3'd1, 5'd1, 5'd1, 32'd8), enc_br(3'd1, 5'd1, 5'd0, 32'd8),
                enc_addi(5'd4, 5'd0, 32'd4), enc_br(3'd4, 5'd1, 5'd1, 32'd8), enc_addi(5'd5, 5'd0, 32'd5)};
        load_program(prog);
        release_reset();
        run_and_compare(7, "branch");
    endtask

    task automatic test_reset_mid();
        logic [31:0] prog[$];
        bit          early;
        prog = {enc_addi(5'd1, 5'd0, 32'd9)};
        load_program(prog);
        release_reset();
        early = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge w_clock);
            if (w_retire !== 1'b0) early = 1;
        end
        n_tests++;
        if (w_state !== 3'd2 || early) begin
            n_fail++;
            $display("FAIL reset_mid setup: state=%0d early_retire=%b, want 2/0", w_state, early);
        end
        w_rst = 1'b1;
        @(negedge w_clock);
        n_tests++;
        if (w_pc !== 32'h0 || w_state !== 3'd0 || w_retire !== 1'b0 || w_wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid abort: pc=%h state=%0d retire=%b wb_en=%b, want 0/0/0/0",
                     w_pc, w_state, w_retire, w_wb_en);
        end
        model_reset();
        release_reset();
        run_and_compare(1, "reset_mid_rerun");
    endtask

    task automatic test_imem_collision();
        logic [31:0] prog[$];
        prog = {enc_addi(5'd1, 5'd0, 32'd5)};
        load_program(prog);
        @(posedge w_clock);
        #1;
        w_rst        = 1'b0;
        w_imem_we    = 1'b1;
        w_imem_waddr = 32'h0;
        w_imem_wdata = enc_addi(5'd1, 5'd0, 32'd6);
        run_and_compare(1, "imem_old_word");
        w_imem_we = 1'b0;
        m_imem[0] = enc_addi(5'd1, 5'd0, 32'd6);
        w_rst = 1'b1;
        model_reset();
        release_reset();
        run_and_compare(1, "imem_new_word");
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = $urandom;
        case ($urandom_range(0, 8))
            0: return enc_addi(rd, rs1, imm);
            1: return enc_add(rd, rs1, rs2);
            2: return enc_sub(rd, rs1, rs2);
            3: return enc_lui(rd, imm);
            4: return enc_lw(rd, rs1, imm);
            5: return enc_sw(rs2, rs1, imm);
            6: return {imm[31:15], 3'b011, rd, 7'h13};
            7: return enc_lw(rd, 5'd0, {24'h0, imm[7:2], 2'b00});
            default: return enc_sw(rs2, 5'd0, {24'h0, imm[7:2], 2'b00});
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] prog[$];
        for (int r = 0; r < 3; r++) begin
            prog = {};
            for (int i = 0; i < IW; i++) prog.push_back(rand_insn());
            load_program(prog);
            release_reset();
            run_and_compare(80, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi_chain();
        test_add_sub();
        test_lui_mem();
        test_halt();
        test_branch();
        test_reset_mid();
        test_imem_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
